// File: rtl/line_sensor_conditioner.sv
// Debounce/conditioning front-end for three line-follower sensors {front, left, right}.
// Raw bits are synchronized, then each one commits a new level only after debounce_len
// consecutive sample ticks agree.
module line_sensor_conditioner #(
  parameter int PRESCALE    = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] sens_raw,
  input  logic [7:0] debounce_len,
  input  logic       glitch_clr,
  output logic [2:0] sens_clean,
  output logic       sens_valid,
  output logic       sens_changed,
  output logic [7:0] glitch_cnt
);

  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} ch_state_e;

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [2:0]  sync_q [SYNC_STAGES];
  logic [2:0]  sync_d [SYNC_STAGES];
  logic [15:0] pre_q, pre_d;
  ch_state_e   st_q  [3];
  ch_state_e   st_d  [3];
  logic [7:0]  cnt_q [3];
  logic [7:0]  cnt_d [3];
  logic [7:0]  len_q [3];
  logic [7:0]  len_d [3];
  logic [2:0]  clean_q, clean_d;
  logic        valid_q, valid_d;
  logic        changed_q, changed_d;
  logic [7:0]  glitch_q, glitch_d;

  logic [2:0]  s;
  logic        tick;
  logic [7:0]  eff_len;
  logic [2:0]  commit;
  logic [2:0]  glitch;
  logic [1:0]  glitch_add;
  logic [8:0]  glitch_sum;

  assign s            = sync_q[SYNC_STAGES-1];
  assign tick         = ena && (pre_q == PRE_MAX);
  assign eff_len      = (debounce_len == 8'd0) ? 8'd1 : debounce_len;
  assign sens_clean   = clean_q;
  assign sens_valid   = valid_q;
  assign sens_changed = changed_q;
  assign glitch_cnt   = glitch_q;

  // Next-state logic: synchronizer shift, prescaler, per-channel debounce FSMs, glitch tally.
  always_comb begin
    sync_d[0] = sens_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    if (!ena) begin
      pre_d = pre_q;
    end else if (tick) begin
      pre_d = 16'd0;
    end else begin
      pre_d = pre_q + 16'd1;
    end

    for (int i = 0; i < 3; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      len_d[i] = len_q[i];
    end
    clean_d   = clean_q;
    valid_d   = valid_q;
    commit    = 3'b000;
    glitch    = 3'b000;
    // Outside tick cycles the pulse drops, but a frozen block (ena=0) holds it.
    changed_d = ena ? 1'b0 : changed_q;

    if (tick) begin
      if (!valid_q) begin
        clean_d = s;
        valid_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          st_d[i]  = STABLE;
          cnt_d[i] = 8'd0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          case (st_q[i])
            STABLE: begin
              if (s[i] == clean_q[i]) begin
                st_d[i] = STABLE;
              end else if (eff_len == 8'd1) begin
                commit[i] = 1'b1;
              end else begin
                len_d[i] = eff_len;
                cnt_d[i] = 8'd1;
                st_d[i]  = PENDING;
              end
            end
            PENDING: begin
              // Compared against the length latched on entry, so live debounce_len edits wait.
              if (s[i] == clean_q[i]) begin
                glitch[i] = 1'b1;
                st_d[i]   = STABLE;
                cnt_d[i]  = 8'd0;
              end else if ((cnt_q[i] + 8'd1) == len_q[i]) begin
                commit[i] = 1'b1;
                st_d[i]   = STABLE;
                cnt_d[i]  = 8'd0;
              end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
              end
            end
            default: begin
              st_d[i]  = STABLE;
              cnt_d[i] = 8'd0;
            end
          endcase
        end
        clean_d   = (clean_q & ~commit) | (s & commit);
        changed_d = |commit;
      end
    end else begin
      clean_d = clean_q;
    end

    glitch_add = {1'b0, glitch[2]} + {1'b0, glitch[1]} + {1'b0, glitch[0]};
    glitch_sum = {1'b0, glitch_q} + {7'd0, glitch_add};
    if (glitch_clr) begin
      glitch_d = 8'd0;
    end else if (glitch_sum > 9'd255) begin
      glitch_d = 8'd255;
    end else begin
      glitch_d = glitch_sum[7:0];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 3'b000;
      end
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= STABLE;
        cnt_q[i] <= 8'd0;
        len_q[i] <= 8'd0;
      end
      pre_q     <= 16'd0;
      clean_q   <= 3'b000;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        len_q[i] <= len_d[i];
      end
      pre_q     <= pre_d;
      clean_q   <= clean_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      glitch_q  <= glitch_d;
    end
  end

endmodule

// File: tb/tb_line_sensor_conditioner.sv
// Directed bench for line_sensor_conditioner with PRESCALE=4, SYNC_STAGES=2.
// Inputs change #1 after a tick edge, so they are seen by the following tick.
module tb_line_sensor_conditioner;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [2:0] sens_raw;
  logic [7:0] debounce_len;
  logic       glitch_clr;
  logic [2:0] sens_clean;
  logic       sens_valid;
  logic       sens_changed;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  line_sensor_conditioner #(.PRESCALE(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .sens_raw     (sens_raw),
    .debounce_len (debounce_len),
    .glitch_clr   (glitch_clr),
    .sens_clean   (sens_clean),
    .sens_valid   (sens_valid),
    .sens_changed (sens_changed),
    .glitch_cnt   (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] raw;
    logic [7:0] dlen;
    logic       clr;
    logic [2:0] e_clean;
    logic       e_chg;
    logic [7:0] e_glitch;
  } vec_t;

  vec_t vecs [20];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // each vector advances exactly one tick (4 cycles)
    vecs[0]  = '{3'b000, 8'd3, 1'b0, 3'b101, 1'b0, 8'd0};
    vecs[1]  = '{3'b000, 8'd3, 1'b0, 3'b101, 1'b0, 8'd0};
    vecs[2]  = '{3'b000, 8'd3, 1'b0, 3'b000, 1'b1, 8'd0};
    vecs[3]  = '{3'b000, 8'd3, 1'b0, 3'b000, 1'b0, 8'd0};
    vecs[4]  = '{3'b100, 8'd3, 1'b0, 3'b000, 1'b0, 8'd0};
    vecs[5]  = '{3'b100, 8'd3, 1'b0, 3'b000, 1'b0, 8'd0};
    vecs[6]  = '{3'b100, 8'd3, 1'b0, 3'b100, 1'b1, 8'd0};
    vecs[7]  = '{3'b100, 8'd3, 1'b0, 3'b100, 1'b0, 8'd0};
    vecs[8]  = '{3'b110, 8'd3, 1'b0, 3'b100, 1'b0, 8'd0};
    vecs[9]  = '{3'b100, 8'd3, 1'b0, 3'b100, 1'b0, 8'd1};
    vecs[10] = '{3'b100, 8'd3, 1'b0, 3'b100, 1'b0, 8'd1};
    vecs[11] = '{3'b101, 8'd0, 1'b0, 3'b101, 1'b1, 8'd1};
    vecs[12] = '{3'b100, 8'd0, 1'b0, 3'b100, 1'b1, 8'd1};
    vecs[13] = '{3'b100, 8'd0, 1'b0, 3'b100, 1'b0, 8'd1};
    vecs[14] = '{3'b110, 8'd2, 1'b0, 3'b100, 1'b0, 8'd1};
    vecs[15] = '{3'b110, 8'd5, 1'b0, 3'b110, 1'b1, 8'd1};
    vecs[16] = '{3'b110, 8'd3, 1'b0, 3'b110, 1'b0, 8'd1};
    vecs[17] = '{3'b001, 8'd1, 1'b0, 3'b001, 1'b1, 8'd1};
    vecs[18] = '{3'b001, 8'd1, 1'b0, 3'b001, 1'b0, 8'd1};
    vecs[19] = '{3'b001, 8'd1, 1'b1, 3'b001, 1'b0, 8'd0};

    reset        = 1'b1;
    ena          = 1'b1;
    sens_raw     = 3'b101;
    debounce_len = 8'd3;
    glitch_clr   = 1'b0;
    step(3);
    chk("reset_clean", 32'(sens_clean), 32'h0);
    chk("reset_valid", 32'(sens_valid), 32'h0);
    chk("reset_changed", 32'(sens_changed), 32'h0);
    chk("reset_glitch", 32'(glitch_cnt), 32'h0);

    reset = 1'b0;
    step(3);
    chk("pre_tick_valid", 32'(sens_valid), 32'h0);
    step(1);
    chk("first_tick_clean", 32'(sens_clean), 32'h5);
    chk("first_tick_valid", 32'(sens_valid), 32'h1);
    chk("first_tick_changed", 32'(sens_changed), 32'h0);

    for (int i = 0; i < 20; i++) begin
      sens_raw     = vecs[i].raw;
      debounce_len = vecs[i].dlen;
      glitch_clr   = vecs[i].clr;
      step(4);
      chk($sformatf("vec%0d_clean", i), 32'(sens_clean), 32'(vecs[i].e_clean));
      chk($sformatf("vec%0d_changed", i), 32'(sens_changed), 32'(vecs[i].e_chg));
      chk($sformatf("vec%0d_glitch", i), 32'(glitch_cnt), 32'(vecs[i].e_glitch));
    end
    glitch_clr = 1'b0;

    // glitch saturation: clean=001, every round is one tick away and one tick back
    debounce_len = 8'd3;
    for (int r = 0; r < 84; r++) begin
      sens_raw = 3'b110;
      step(4);
      sens_raw = 3'b001;
      step(4);
    end
    chk("glitch_252", 32'(glitch_cnt), 32'd252);
    sens_raw = 3'b111;
    step(4);
    sens_raw = 3'b001;
    step(4);
    chk("glitch_254", 32'(glitch_cnt), 32'd254);
    sens_raw = 3'b110;
    step(4);
    sens_raw = 3'b001;
    step(4);
    chk("glitch_sat", 32'(glitch_cnt), 32'd255);
    chk("glitch_sat_clean", 32'(sens_clean), 32'h1);
    sens_raw = 3'b110;
    step(4);
    sens_raw = 3'b001;
    step(3);
    glitch_clr = 1'b1;
    step(1);
    chk("clr_beats_glitch", 32'(glitch_cnt), 32'd0);
    glitch_clr = 1'b0;

    // ena low freezes prescaler and outputs
    sens_raw     = 3'b000;
    debounce_len = 8'd0;
    ena          = 1'b0;
    step(10);
    chk("freeze_clean", 32'(sens_clean), 32'h1);
    chk("freeze_changed", 32'(sens_changed), 32'h0);
    ena = 1'b1;
    step(3);
    chk("thaw_no_tick_yet", 32'(sens_clean), 32'h1);
    step(1);
    chk("thaw_commit_clean", 32'(sens_clean), 32'h0);
    chk("thaw_commit_changed", 32'(sens_changed), 32'h1);

    // reset during a pending front change
    sens_raw     = 3'b011;
    debounce_len = 8'd1;
    step(4);
    chk("pre_reset_commit", 32'(sens_clean), 32'h3);
    sens_raw     = 3'b001;
    debounce_len = 8'd3;
    step(4);
    sens_raw = 3'b011;
    step(4);
    chk("pre_reset_glitch", 32'(glitch_cnt), 32'd1);
    sens_raw = 3'b111;
    step(8);
    chk("pending_cnt2_clean", 32'(sens_clean), 32'h3);
    reset = 1'b1;
    #1;
    chk("async_reset_clean", 32'(sens_clean), 32'h0);
    chk("async_reset_valid", 32'(sens_valid), 32'h0);
    chk("async_reset_glitch", 32'(glitch_cnt), 32'h0);
    step(3);
    reset = 1'b0;
    step(3);
    chk("rerelease_valid", 32'(sens_valid), 32'h0);
    step(1);
    chk("rerelease_clean", 32'(sens_clean), 32'h7);
    chk("rerelease_valid1", 32'(sens_valid), 32'h1);
    chk("rerelease_changed", 32'(sens_changed), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_sensor_conditioner.md
LINE_SENSOR_CONDITIONER -- requirements
Module: line_sensor_conditioner

Interface
REQ-001 Parameter: PRESCALE, default 100, clock cycles per sample tick (legal range 2..65535).
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth on raw sensor inputs (legal range 2..3).
REQ-003 Port: clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: ena  in  1  enable; when low, prescaler, channel FSMs, counters and outputs hold their values.
REQ-006 Port: sens_raw  in  3  unsynchronized sensors {front, left, right}, bit 2 = front, bit 0 = right.
REQ-007 Port: debounce_len  in  8  required count of consecutive differing ticks before a change commits; 0 is treated as 1.
REQ-008 Port: glitch_clr  in  1  synchronous clear of glitch_cnt.
REQ-009 Port: sens_clean  out  3  debounced sensors, same bit order as sens_raw; feeds the motor-control FSM.
REQ-010 Port: sens_valid  out  1  high once sens_clean holds real data.
REQ-011 Port: sens_changed  out  1  one-cycle pulse marking any sens_clean update.
REQ-012 Port: glitch_cnt  out  8  saturating count of rejected glitches, summed over all channels.

Function
REQ-013 Each sens_raw bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is called s[i].
REQ-014 The prescaler SHALL count 0..PRESCALE-1 while ena=1, wrap to 0, and assert tick for the one cycle in which it equals PRESCALE-1.
REQ-015 Channel FSM states and all debounce decisions SHALL change only on tick cycles with ena=1.
REQ-016 First tick after reset: sens_clean <= s, sens_valid <= 1, sens_changed stays 0, and all channels go to STABLE.
REQ-017 Each channel SHALL have a two-state FSM: STABLE and PENDING, with a per-channel 8-bit counter cnt.
REQ-018 STABLE, tick, s[i]==sens_clean[i]: no change.
REQ-019 STABLE, tick, s[i]!=sens_clean[i], effective length L==1: commit immediately and remain STABLE.
REQ-020 STABLE, tick, s[i]!=sens_clean[i], L>1: latch L for this channel, set cnt=1, go to PENDING.
REQ-021 PENDING, tick, s[i]==sens_clean[i]: glitch; go to STABLE, clear cnt, and add 1 to the glitch tally.
REQ-022 PENDING, tick, s[i]!=sens_clean[i]: cnt+1; if cnt+1 equals the latched L, commit and go to STABLE.
REQ-023 Commit: sens_clean[i] <= s[i] and sens_changed <= 1 in the same clock edge; sens_changed deasserts next cycle unless another commit occurs.
REQ-024 A change of debounce_len while a channel is PENDING SHALL NOT affect that channel until its next entry to PENDING.
REQ-025 glitch_cnt SHALL add the number of channels glitching in the same tick (0..3) and saturate at 255.
REQ-026 glitch_clr SHALL set glitch_cnt to 0 and take priority over a same-cycle increment.
REQ-027 Commits on several channels in the same tick SHALL update all bits together and produce one sens_changed pulse.
REQ-028 Latency from a raw edge to a committed sens_clean bit SHALL be SYNC_STAGES cycles to the sync output, plus the wait to the next tick, plus (L-1)*PRESCALE cycles, plus 1 cycle for the register update.

Reset
REQ-029 While reset=1, and immediately on its assertion, the block SHALL force: sens_clean=000, sens_valid=0, sens_changed=0, glitch_cnt=0, prescaler=0, all channels STABLE with cnt=0, and all synchronizer flops to 0.
REQ-030 Reset asserted mid-PENDING SHALL discard the pending change; after release, behaviour SHALL restart from REQ-016.

Verification
REQ-031 PRESCALE=4, SYNC_STAGES=2, sens_raw=101 held, release reset -> first tick at cycle 4: sens_clean=101, sens_valid=1, sens_changed=0.
REQ-032 Stable 000, debounce_len=3, front bit rises and is held -> sens_clean=100 on the 3rd tick seeing 1, with a single sens_changed pulse and glitch_cnt=0.
REQ-033 debounce_len=3, left bit high for 1 tick then low -> sens_clean unchanged, no sens_changed pulse, glitch_cnt=1.
REQ-034 All three bits glitch in the same tick, starting from glitch_cnt=254 -> glitch_cnt=255; glitch_clr asserted in the same cycle as a new glitch -> glitch_cnt=0.
REQ-035 debounce_len=0, right bit toggles -> commit on the first tick seeing the new value; ena=0 held for 10 cycles -> prescaler and outputs frozen.
REQ-036 Reset asserted while front bit is PENDING with cnt=2 -> outputs clear at once; after release sens_clean equals the current raw value at the first tick.
